mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter; responds to the core's data-memory bus (r, w[3:0], addr, in -> out)
//  alongside RAM. Core writes bytes to a FIFO; an 8N1 serializer drives tx. Gives firmware console output.
//  Read data is combinational, for the single-cycle core; writes commit on posedge clk.
// PARAMETERS
//  BASE_ADDR    32'h8000_0000  16-byte aligned window; decoded when addr[31:4] == BASE_ADDR[31:4]
//  FIFO_DEPTH   8              TX FIFO entries, power of 2, >= 2
//  DEFAULT_DIV  16             reset value of DIVISOR (clk cycles per serial bit)
// PORTS
//  clk     in   1   system clock, rising edge
//  rst_n   in   1   asynchronous active-low reset
//  r       in   1   bus read enable
//  w       in   4   bus byte write strobes; w[i] qualifies in[8i+7:8i]
//  addr    in   32  bus byte address
//  in      in   32  bus write data (core store data)
//  out     out  32  bus read data; 0 when not selected or r=0
//  tx      out  1   serial output, idle high
//  irq     out  1   level: FIFO empty and serializer idle
// BEHAVIOUR
//  Register map (offset = addr[3:2]; addr[1:0] ignored):
//   0x0 TXDATA  W: w[0]=1 pushes in[7:0]; other lanes ignored. R: 0
//   0x4 STATUS  R: [0] busy (FSM!=IDLE), [1] full, [2] empty, [3] overflow, [15:8] count. W: w[0]&in[3] clears overflow
//   0x8 DIVISOR R/W [15:0], byte lanes w[0],w[1]; bits [31:16] read 0
//   0xC reserved: reads 0, writes ignored
//  Reset: tx=1, irq=1, out=0 (no read), FIFO empty, overflow=0, DIVISOR=DEFAULT_DIV, FSM=IDLE.
//  Reads: no side effects; out = register value in the same cycle r and decode are true.
//  Push when full: byte dropped, overflow set (sticky), even if the FSM pops that same edge.
//  Overflow set and clear on the same edge: set wins.
//  FSM IDLE -> START -> DATA -> STOP:
//   IDLE: if FIFO non-empty, pop into shift reg, latch divisor (0 treated as 1) into bit_div, -> START.
//   START: tx=0 for bit_div cycles. DATA: 8 bits LSB first, bit_div cycles each. STOP: tx=1 for bit_div cycles.
//   Last STOP cycle: if FIFO non-empty, pop and -> START directly (no idle gap); else -> IDLE.
//  Timing: write to TXDATA at edge N (FIFO empty, IDLE) -> count=1 after N; pop at N+1, tx=0 from N+1.
//   Frame = exactly 10*bit_div cycles. tx is registered (glitch-free).
//  DIVISOR writes mid-frame take effect at the next frame start.
//  Baud counter counts bit_div-1 down to 0; bit index 0..7 in DATA, no wrap beyond 7.
//  FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
//  rst_n low mid-frame: tx=1 immediately (async), frame abandoned, FIFO flushed.
// STRUCTURE
//  Package uart_pkg: register offsets (TXDATA/STATUS/DIVISOR), STATUS bit indices, FSM state enum.
//  One sub-module: sync_fifo #(WIDTH=8, DEPTH) with push/pop/full/empty/count, async active-low reset.
//  Top: address decode, register file, read mux, serializer FSM.
// TESTING
//  1 Reset: rst_n=0 -> tx=1, irq=1, STATUS read = 0x0000_0004, DIVISOR read = 16.
//  2 DIV=4, write 0x55 to TXDATA -> tx low 1 edge later; 40 cycles: 0,1,0,1,0,1,0,1,0,1 per 4 cycles; irq=1 after.
//  3 Write 3 bytes back-to-back, DIV=2 -> 3 frames contiguous, 60 cycles, no idle high between STOP and START.
//  4 Write 9 bytes, DEPTH=8, DIV=16 -> first popped so 8 queued; with busy stall, 10th write sets overflow; STATUS[3]=1; write 0x8 to STATUS clears it.
//  5 Write DIVISOR=8 mid-frame at DIV=4 -> current frame stays 40 cycles; next frame 80 cycles.
//  6 Assert rst_n mid-DATA bit -> tx=1 without a clock edge; after release STATUS empty, no residual frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and serializer states.
package uart_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DIVISOR = 2'd2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full or a pop while
// empty is ignored. Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, TXDATA/STATUS/DIVISOR
// registers, combinational read mux and a FIFO-fed serializer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line high, waiting for the FIFO to hold a byte
// ST_START | start bit (tx=0) for bit_div cycles
// ST_DATA  | 8 data bits, LSB first, bit_div cycles each
// ST_STOP  | stop bit (tx=1); last cycle chains straight into the next frame
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r,
    input  logic [3:0]  w,
    input  logic [31:0] addr,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [1:0]    offset;
    logic          wr_txdata;
    logic          clr_overflow;
    logic [15:0]   divisor;
    logic          overflow;
    logic [31:0]   status_word;

    logic          fifo_pop;
    logic [7:0]    fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_state_e     state;
    logic [7:0]    shift_reg;
    logic [15:0]   bit_div;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [15:0]   eff_div;
    logic          baud_done;
    logic          busy;

    logic          unused_bus;
    assign unused_bus = ^{w[3:2], addr[1:0], in[31:16]};

    assign sel          = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset       = addr[3:2];
    assign wr_txdata    = sel && w[0] && (offset == OFF_TXDATA);
    assign clr_overflow = sel && w[0] && in[3] && (offset == OFF_STATUS);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_txdata),
        .pop     (fifo_pop),
        .wr_data (in[7:0]),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor <= DEFAULT_DIV;
        end else if (sel && (offset == OFF_DIVISOR)) begin
            if (w[0]) begin
                divisor[7:0] <= in[7:0];
            end
            if (w[1]) begin
                divisor[15:8] <= in[15:8];
            end
        end
    end

    // A push that finds the FIFO full is dropped even if the serializer frees
    // a slot on the same edge; setting outranks a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_txdata && fifo_full) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        status_word                                 = '0;
        status_word[STAT_BUSY]                      = busy;
        status_word[STAT_FULL]                      = fifo_full;
        status_word[STAT_EMPTY]                     = fifo_empty;
        status_word[STAT_OVERFLOW]                  = overflow;
        status_word[STAT_COUNT_LSB +: 8]            = 8'(fifo_count);
    end

    always_comb begin
        out = '0;
        if (r && sel) begin
            unique case (offset)
                OFF_STATUS:  out = status_word;
                OFF_DIVISOR: out = {16'h0000, divisor};
                default:     out = '0;
            endcase
        end
    end

    assign eff_div   = (divisor == 16'd0) ? 16'd1 : divisor;
    assign baud_done = (baud_cnt == 16'd0);
    assign busy      = (state != ST_IDLE);
    assign irq       = fifo_empty && (state == ST_IDLE);
    assign fifo_pop  = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_STOP) && baud_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_div   <= 16'd1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx        <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state     <= ST_START;
                        shift_reg <= fifo_rd_data;
                        bit_div   <= eff_div;
                        baud_cnt  <= eff_div - 16'd1;
                        tx        <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        state    <= ST_DATA;
                        bit_idx  <= '0;
                        baud_cnt <= bit_div - 16'd1;
                        tx       <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= bit_div - 16'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        if (!fifo_empty) begin
                            state     <= ST_START;
                            shift_reg <= fifo_rd_data;
                            bit_div   <= eff_div;
                            baud_cnt  <= eff_div - 16'd1;
                            tx        <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue-and-frame-position model predicts tx, irq and
// read data every cycle; directed scenarios add hand-computed literal checks.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r = 1'b0;
    logic [3:0]  w = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] bus_in = 32'h0;
    logic [31:0] out;
    logic        tx;
    logic        irq;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .r     (r),
        .w     (w),
        .addr  (addr),
        .in    (bus_in),
        .out   (out),
        .tx    (tx),
        .irq   (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mq[$];
    bit          m_active;
    int          m_pos;
    int          m_bdiv;
    logic [9:0]  m_frame;
    logic [15:0] m_div;
    bit          m_ovf;
    int          cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_tx();
        return m_active ? m_frame[m_pos / m_bdiv] : 1'b1;
    endfunction

    function automatic logic m_irq();
        return (mq.size() == 0) && !m_active;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] s;
        s = 32'h0;
        if (a[31:4] == BASE[31:4]) begin
            if (a[3:2] == 2'd1) begin
                s[15:8] = 8'(mq.size());
                s[0] = m_active;
                s[1] = (mq.size() == DEPTH);
                s[2] = (mq.size() == 0);
                s[3] = m_ovf;
            end else if (a[3:2] == 2'd2) begin
                s = {16'h0, m_div};
            end
        end
        return s;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_pos    = 0;
        m_bdiv   = 1;
        m_frame  = 10'h3FF;
        m_div    = 16'd16;
        m_ovf    = 0;
    endtask

    // One clock edge: serializer first (sees pre-edge queue and divisor), then the bus.
    task automatic model_step();
        bit was_full;
        bit has_data;
        bit pop;
        logic [7:0] d;
        was_full = (mq.size() == DEPTH);
        has_data = (mq.size() != 0);
        pop = 0;
        if (m_active) begin
            if (m_pos == 10 * m_bdiv - 1) begin
                m_active = 0;
                pop = has_data;
            end else begin
                m_pos++;
            end
        end else begin
            pop = has_data;
        end
        if (pop) begin
            d = mq.pop_front();
            m_bdiv   = (m_div == 16'd0) ? 1 : int'(m_div);
            m_frame  = {1'b1, d, 1'b0};
            m_pos    = 0;
            m_active = 1;
        end
        if (addr[31:4] == BASE[31:4]) begin
            case (addr[3:2])
                2'd0: if (w[0]) begin
                    if (was_full) m_ovf = 1;
                    else mq.push_back(bus_in[7:0]);
                end
                2'd1: if (w[0] && bus_in[3]) m_ovf = 0;
                2'd2: begin
                    if (w[0]) m_div[7:0]  = bus_in[7:0];
                    if (w[1]) m_div[15:8] = bus_in[15:8];
                end
                default: ;
            endcase
        end
        cyc++;
    endtask

    task automatic run_model();
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("tx", {31'h0, tx}, {31'h0, m_tx()});
            check("irq", {31'h0, irq}, {31'h0, m_irq()});
            if (r) check("out", out, m_read(addr));
        end
    endtask

    // Bus tasks are entered and left 1 time unit after a rising edge.
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        addr = a; bus_in = d; w = we; r = 1'b0;
        sync();
        w = 4'h0; bus_in = 32'h0; addr = 32'h0;
    endtask

    task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string name);
        r = 1'b1; addr = a;
        @(negedge clk);
        check(name, out, exp);
        sync();
        r = 1'b0; addr = 32'h0;
    endtask

    task automatic at_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (k < limit && irq !== 1'b1);
        check("idle_reached", {31'h0, irq}, 32'h1);
    endtask

    initial begin
        int t0;
        logic [9:0] pat;
        fork
            run_model();
            compare_loop();
        join_none

        // Reset values, read while reset is held
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'h0, tx}, 32'h1);
        check("reset_irq", {31'h0, irq}, 32'h1);
        read_check(BASE + 32'h4, 32'h0000_0004, "reset_status");
        read_check(BASE + 32'h8, 32'h0000_0010, "reset_div");
        rst_n = 1'b1;
        sync();

        // Register map corners
        bus_write(BASE + 32'h8, 32'h0000_AB00, 4'b0010);
        read_check(BASE + 32'h8, 32'h0000_AB10, "div_lane1");
        bus_write(BASE + 32'h8, 32'hFFFF_0004, 4'b1111);
        read_check(BASE + 32'hA, 32'h0000_0004, "div_hi_zero");
        bus_write(32'h9000_0000, 32'h41, 4'b0001);
        read_check(BASE + 32'h4, 32'h0000_0004, "miss_write_ignored");
        read_check(32'h9000_0004, 32'h0, "miss_read");
        read_check(BASE + 32'hC, 32'h0, "reserved_read");
        read_check(BASE + 32'h0, 32'h0, "txdata_read");

        // 0x55 at DIV=4
        bus_write(BASE + 32'h0, 32'h55, 4'b0001);
        @(negedge clk);
        check("pre_start_tx", {31'h0, tx}, 32'h1);
        check("pre_start_irq", {31'h0, irq}, 32'h0);
        pat = 10'b1010101010;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("frame55", {31'h0, tx}, {31'h0, pat[i / 4]});
        end
        @(negedge clk);
        check("irq_after_frame", {31'h0, irq}, 32'h1);
        sync();

        // Three contiguous frames at DIV=2
        bus_write(BASE + 32'h8, 32'h2, 4'b0011);
        bus_write(BASE + 32'h0, 32'hA5, 4'b0001);
        t0 = cyc;
        bus_write(BASE + 32'h0, 32'h3C, 4'b0001);
        bus_write(BASE + 32'h0, 32'hF0, 4'b0001);
        wait_idle(500);
        check("contig_len", 32'(cyc - t0 - 1), 32'd60);
        sync();

        // DIVISOR=0 behaves as 1
        bus_write(BASE + 32'h8, 32'h0, 4'b0011);
        bus_write(BASE + 32'h0, 32'h96, 4'b0001);
        t0 = cyc;
        wait_idle(100);
        check("div0_len", 32'(cyc - t0 - 1), 32'd10);
        sync();

        // DIVISOR change mid-frame applies to the next frame only
        bus_write(BASE + 32'h8, 32'h4, 4'b0011);
        bus_write(BASE + 32'h0, 32'hFF, 4'b0001);
        t0 = cyc;
        repeat (10) sync();
        bus_write(BASE + 32'h8, 32'h8, 4'b0011);
        bus_write(BASE + 32'h0, 32'hFF, 4'b0001);
        at_cycle(t0 + 40);
        check("f1_stop", {31'h0, tx}, 32'h1);
        at_cycle(t0 + 41);
        check("f2_start", {31'h0, tx}, 32'h0);
        at_cycle(t0 + 45);
        check("f2_start_long", {31'h0, tx}, 32'h0);
        at_cycle(t0 + 49);
        check("f2_d0", {31'h0, tx}, 32'h1);
        wait_idle(500);
        check("div_change_len", 32'(cyc - t0 - 1), 32'd120);
        sync();

        // Overflow at DIV=16
        bus_write(BASE + 32'h8, 32'h10, 4'b0011);
        for (int i = 0; i < 10; i++) bus_write(BASE + 32'h0, 32'h30 + 32'(i), 4'b0001);
        read_check(BASE + 32'h4, 32'h0000_080B, "ovf_status");
        bus_write(BASE + 32'h4, 32'h8, 4'b0001);
        read_check(BASE + 32'h4, 32'h0000_0803, "ovf_cleared");
        wait_idle(3000);
        read_check(BASE + 32'h4, 32'h0000_0004, "drained_status");

        // Asynchronous reset in the middle of a data bit
        bus_write(BASE + 32'h8, 32'h4, 4'b0011);
        bus_write(BASE + 32'h0, 32'h00, 4'b0001);
        t0 = cyc;
        bus_write(BASE + 32'h0, 32'h11, 4'b0001);
        at_cycle(t0 + 8);
        check("mid_data_tx", {31'h0, tx}, 32'h0);
        #1 rst_n = 1'b0;
        #1 check("async_rst_tx", {31'h0, tx}, 32'h1);
        repeat (2) sync();
        rst_n = 1'b1;
        sync();
        read_check(BASE + 32'h4, 32'h0000_0004, "post_rst_status");
        repeat (30) sync();
        check("post_rst_idle_tx", {31'h0, tx}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
